// File: rtl/banked_ram_controller.sv
// banked_ram_controller
//   Pipelined controller for a bank-interleaved array of single-port
//   synchronous SRAM macros. A request is accepted on the valid/ready port.
//   It drives the shared macro pins for one cycle. Its response is
//   registered two edges later. A hardware sweep fills every word with
//   INIT_VALUE after reset, or when init_start is raised.
//
// Ports
//   wb_clk_i, rst_n            clock (rising edge), async active-low reset
//   ram_enabled                RAM window enable, sampled at acceptance
//   req_valid/ready/we/addr/wdata   request port
//   rsp_valid/we/err/rdata     one-cycle response pulse, no backpressure
//   init_start/busy/done       init sweep control and status
//   CEN_all, A_all, D_all      shared macro chip enable (low), row, data
//   WEN_all                    macro bit write enables (low), tied active
//   GWEN                       per-bank global write enable (low)
//   Q_flat                     macro read data, bank k at [k*DW +: DW]
module banked_ram_controller #(
  parameter int unsigned     AW            = 16,
  parameter int unsigned     DW            = 8,
  parameter int unsigned     BANKS         = 8,
  parameter int unsigned     BANK_AW       = 9,
  parameter bit              INIT_ON_RESET = 1'b1,
  parameter logic [DW-1:0]   INIT_VALUE    = '0
) (
  input  logic                  wb_clk_i,
  input  logic                  rst_n,
  input  logic                  ram_enabled,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [AW-1:0]         req_addr,
  input  logic [DW-1:0]         req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_we,
  output logic                  rsp_err,
  output logic [DW-1:0]         rsp_rdata,
  input  logic                  init_start,
  output logic                  init_busy,
  output logic                  init_done,
  output logic                  CEN_all,
  output logic [BANK_AW-1:0]    A_all,
  output logic [DW-1:0]         D_all,
  output logic [DW-1:0]         WEN_all,
  output logic [BANKS-1:0]      GWEN,
  input  logic [BANKS*DW-1:0]   Q_flat
);

  localparam int unsigned BW = $clog2(BANKS);
  localparam int unsigned CW = AW + 1;
  // Capacity at AW+1 bits so a fully populated window still compares cleanly.
  localparam logic [CW-1:0]      CAPACITY = CW'(BANKS) << BANK_AW;
  localparam logic [BANK_AW-1:0] LAST_ROW = '1;

  typedef enum logic {RUN, SWEEP} state_t;

  state_t             state;
  logic               live_q;
  logic [BANK_AW-1:0] row_cnt;

  // Stage 1: the macro cycle (pin registers double as stage-1 payload)
  logic               s1_valid, s1_we, s1_err;
  logic [BW-1:0]      s1_bank;
  // Stage 2: macro output valid, selects the bank for the response
  logic               s2_valid, s2_we, s2_err, s2_rd;
  logic [BW-1:0]      s2_bank;

  logic [BW-1:0]      req_bank;
  logic [BANK_AW-1:0] req_row;
  logic               req_err;
  logic               accept;
  logic               sweep_go;
  logic [DW-1:0]      q_sel;

  assign req_bank = req_addr[BW-1:0];
  assign req_row  = req_addr[BW+BANK_AW-1:BW];
  assign req_err  = ({1'b0, req_addr} >= CAPACITY) || !ram_enabled;

  // live_q holds the port closed for the first cycle after reset, so the
  // boot sweep can start without racing an incoming request.
  assign req_ready = (state == RUN) && live_q && !init_start;
  assign accept    = req_valid && req_ready;
  assign sweep_go  = (state == RUN) && (init_start || (!live_q && INIT_ON_RESET));
  assign init_busy = (state == SWEEP);
  assign WEN_all   = '0;

  always_comb begin
    q_sel = '0;
    for (int unsigned k = 0; k < BANKS; k++) begin
      if (s2_bank == BW'(k)) q_sel = Q_flat[k*DW +: DW];
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      live_q    <= 1'b0;
      row_cnt   <= '0;
      s1_valid  <= 1'b0;
      s1_we     <= 1'b0;
      s1_err    <= 1'b0;
      s1_bank   <= '0;
      s2_valid  <= 1'b0;
      s2_we     <= 1'b0;
      s2_err    <= 1'b0;
      s2_rd     <= 1'b0;
      s2_bank   <= '0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      init_done <= 1'b0;
      CEN_all   <= 1'b1;
      GWEN      <= '1;
      A_all     <= '0;
      D_all     <= '0;
    end else begin
      live_q    <= 1'b1;
      init_done <= 1'b0;

      s1_valid  <= accept;
      s1_we     <= accept && req_we;
      s1_err    <= accept && req_err;
      s1_bank   <= req_bank;

      s2_valid  <= s1_valid;
      s2_we     <= s1_we;
      s2_err    <= s1_err;
      s2_rd     <= s1_valid && !s1_we && !s1_err;
      s2_bank   <= s1_bank;

      rsp_valid <= s2_valid;
      rsp_we    <= s2_we;
      rsp_err   <= s2_err;
      rsp_rdata <= s2_rd ? q_sel : '0;

      case (state)
        RUN: begin
          if (sweep_go) begin
            // Port is closed while init_start is high, so stage 1 holds at
            // most the previous request; its macro cycle is this one.
            state   <= SWEEP;
            row_cnt <= '0;
            CEN_all <= 1'b0;
            GWEN    <= '0;
            A_all   <= '0;
            D_all   <= INIT_VALUE;
          end else if (accept && !req_err) begin
            CEN_all <= 1'b0;
            GWEN    <= req_we ? ~(BANKS'(1) << req_bank) : '1;
            A_all   <= req_row;
            D_all   <= req_wdata;
          end else begin
            CEN_all <= 1'b1;
            GWEN    <= '1;
          end
        end
        SWEEP: begin
          if (row_cnt == LAST_ROW) begin
            state     <= RUN;
            row_cnt   <= '0;
            CEN_all   <= 1'b1;
            GWEN      <= '1;
            init_done <= 1'b1;
          end else begin
            row_cnt <= row_cnt + BANK_AW'(1);
            A_all   <= row_cnt + BANK_AW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_banked_ram_controller.sv
// Self-checking bench for banked_ram_controller.
//   Instance A: default geometry (8 banks x 512 rows, 8-bit), INIT_VALUE A5.
//   Instance B: 4 banks x 16 rows, 16-bit, INIT_VALUE BEEF (mid-sweep reset).
// Each instance is backed by a behavioural SRAM macro array. Instance A is
// checked against a flat word-addressed reference memory with a response
// latency queue. Instance B uses directed expectations.
module tb_banked_ram_controller;

  localparam int ROWS_A = 512;
  localparam int CAP_A  = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // ---------------- instance A ----------------
  logic        rst_n, ram_en, req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, rsp_rdata, D_all, WEN_all, GWEN;
  logic        rsp_valid, rsp_we, rsp_err, init_start, init_busy, init_done, CEN_all;
  logic [8:0]  A_all;
  logic [63:0] Q_flat;

  banked_ram_controller #(
    .AW(16), .DW(8), .BANKS(8), .BANK_AW(9),
    .INIT_ON_RESET(1'b1), .INIT_VALUE(8'hA5)
  ) dut_a (
    .wb_clk_i(clk), .rst_n(rst_n), .ram_enabled(ram_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
    .CEN_all(CEN_all), .A_all(A_all), .D_all(D_all), .WEN_all(WEN_all),
    .GWEN(GWEN), .Q_flat(Q_flat)
  );

  logic [7:0] mem_a [8][512];
  always @(posedge clk) begin
    if (!CEN_all) begin
      for (int k = 0; k < 8; k++) begin
        if (!GWEN[k]) begin
          mem_a[k][A_all] <= D_all;
          Q_flat[k*8 +: 8] <= D_all;
        end else begin
          Q_flat[k*8 +: 8] <= mem_a[k][A_all];
        end
      end
    end
  end

  // ---------------- instance B ----------------
  logic        b_rst_n, b_req_valid, b_req_ready, b_req_we;
  logic [15:0] b_req_addr, b_req_wdata, b_rsp_rdata, b_D_all, b_WEN_all;
  logic        b_rsp_valid, b_rsp_we, b_rsp_err, b_init_busy, b_init_done, b_CEN_all;
  logic [3:0]  b_A_all, b_GWEN;
  logic [63:0] b_Q_flat;

  banked_ram_controller #(
    .AW(16), .DW(16), .BANKS(4), .BANK_AW(4),
    .INIT_ON_RESET(1'b1), .INIT_VALUE(16'hBEEF)
  ) dut_b (
    .wb_clk_i(clk), .rst_n(b_rst_n), .ram_enabled(1'b1),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_we(b_rsp_we), .rsp_err(b_rsp_err), .rsp_rdata(b_rsp_rdata),
    .init_start(1'b0), .init_busy(b_init_busy), .init_done(b_init_done),
    .CEN_all(b_CEN_all), .A_all(b_A_all), .D_all(b_D_all), .WEN_all(b_WEN_all),
    .GWEN(b_GWEN), .Q_flat(b_Q_flat)
  );

  logic [15:0] mem_b [4][16];
  always @(posedge clk) begin
    if (!b_CEN_all) begin
      for (int k = 0; k < 4; k++) begin
        if (!b_GWEN[k]) begin
          mem_b[k][b_A_all] <= b_D_all;
          b_Q_flat[k*16 +: 16] <= b_D_all;
        end else begin
          b_Q_flat[k*16 +: 16] <= mem_b[k][b_A_all];
        end
      end
    end
  end

  // ---------------- comparison ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model for instance A ----------------
  logic [7:0] ref_mem [CAP_A];
  bit         ev [3];
  bit         ewe [3];
  bit         eerr [3];
  logic [7:0] edat [3];
  bit         mac_v, mac_we;
  int         mac_bank, mac_row;
  int         sweep_left;
  bit         done_now, boot_pending;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      ev[i] = 0; ewe[i] = 0; eerr[i] = 0; edat[i] = '0;
    end
    mac_v = 0; mac_we = 0; mac_bank = 0; mac_row = 0;
    sweep_left = 0; done_now = 0; boot_pending = 1;
  endtask

  // Called at a negedge: checks this cycle's outputs, drives the next
  // request, predicts the next edge, and returns at the following negedge.
  task automatic step_a(input bit v, input bit we, input int addr,
                        input logic [7:0] wd, input bit en, input bit ist);
    bit         acc, err, rdy;
    logic [7:0] g;
    chk("rsp_valid", 64'(rsp_valid), 64'(ev[0]));
    if (ev[0]) begin
      chk("rsp_we", 64'(rsp_we), 64'(ewe[0]));
      chk("rsp_err", 64'(rsp_err), 64'(eerr[0]));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(edat[0]));
    end
    chk("init_busy", 64'(init_busy), 64'(sweep_left > 0));
    chk("init_done", 64'(init_done), 64'(done_now));
    if (sweep_left > 0) begin
      chk("sweep_CEN", 64'(CEN_all), 64'd0);
      chk("sweep_GWEN", 64'(GWEN), 64'h00);
      chk("sweep_row", 64'(A_all), 64'(ROWS_A - sweep_left));
      chk("sweep_D", 64'(D_all), 64'hA5);
    end else if (mac_v) begin
      g = 8'hFF;
      if (mac_we) g[mac_bank] = 1'b0;
      chk("macro_CEN", 64'(CEN_all), 64'd0);
      chk("macro_GWEN", 64'(GWEN), 64'(g));
      chk("macro_row", 64'(A_all), 64'(mac_row));
    end else begin
      chk("idle_CEN", 64'(CEN_all), 64'd1);
      chk("idle_GWEN", 64'(GWEN), 64'hFF);
    end

    req_valid = v; req_we = we; req_addr = 16'(addr); req_wdata = wd;
    ram_en = en; init_start = ist;
    #1;
    rdy = !boot_pending && (sweep_left == 0) && !ist;
    chk("req_ready", 64'(req_ready), 64'(rdy));

    acc = v && rdy;
    err = (addr >= CAP_A) || !en;
    for (int i = 0; i < 2; i++) begin
      ev[i] = ev[i+1]; ewe[i] = ewe[i+1]; eerr[i] = eerr[i+1]; edat[i] = edat[i+1];
    end
    ev[2] = acc; ewe[2] = we; eerr[2] = err;
    edat[2] = (acc && !we && !err) ? ref_mem[addr] : 8'h00;
    if (acc && we && !err) ref_mem[addr] = wd;
    mac_v = acc && !err; mac_we = we; mac_bank = addr % 8; mac_row = (addr / 8) % ROWS_A;

    done_now = (sweep_left == 1);
    if (sweep_left > 0) sweep_left--;
    else if (boot_pending || ist) begin
      sweep_left = ROWS_A;
      for (int i = 0; i < CAP_A; i++) ref_mem[i] = 8'hA5;
    end
    boot_pending = 0;
    @(negedge clk);
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) step_a(0, 0, 0, 8'h00, 1, 0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_n = 0; ram_en = 1; req_valid = 0; req_we = 0; req_addr = '0;
    req_wdata = '0; init_start = 0;
    b_rst_n = 0; b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0;
    model_reset();

    @(negedge clk); @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(init_busy), 64'd0);
    chk("rst_done", 64'(init_done), 64'd0);
    chk("rst_CEN", 64'(CEN_all), 64'd1);
    chk("rst_GWEN", 64'(GWEN), 64'hFF);
    chk("rst_A", 64'(A_all), 64'd0);
    chk("rst_D", 64'(D_all), 64'd0);
    chk("rst_WEN", 64'(WEN_all), 64'd0);

    // Boot sweep, then reads of corners
    rst_n = 1;
    idle_a(ROWS_A + 1);
    step_a(1, 0, 0, 8'h00, 1, 0);
    step_a(1, 0, 7, 8'h00, 1, 0);
    step_a(1, 0, 4095, 8'h00, 1, 0);
    // Back-to-back write / read-after-write / neighbour read
    step_a(1, 1, 3, 8'h3C, 1, 0);
    step_a(1, 0, 3, 8'h00, 1, 0);
    step_a(1, 0, 4, 8'h00, 1, 0);
    idle_a(3);
    // Out of range write, then read of word 0
    step_a(1, 1, 16'h1000, 8'hFF, 1, 0);
    step_a(1, 0, 0, 8'h00, 1, 0);
    idle_a(3);
    // RAM window disabled
    step_a(1, 1, 16'h0010, 8'h11, 0, 0);
    step_a(1, 0, 16'h0010, 8'h00, 1, 0);
    idle_a(3);
    // Sweep requested right behind a write; requests offered during sweep
    step_a(1, 1, 16'h0020, 8'h77, 1, 0);
    step_a(0, 0, 0, 8'h00, 1, 1);
    for (int i = 0; i < ROWS_A + 1; i++)
      step_a(1, i[0], $urandom_range(0, 63), 8'(i), 1, (i % 97) == 5);
    step_a(1, 0, 16'h0020, 8'h00, 1, 0);
    idle_a(3);
    // Random traffic, clustered on low addresses to hit read-after-write
    for (int i = 0; i < 400; i++) begin
      int a;
      a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 4200));
      step_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
             8'($urandom), $urandom_range(0, 9) != 0, 0);
    end
    idle_a(4);

    // ---------------- instance B: reset during sweep ----------------
    b_rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("b_busy_pre", 64'(b_init_busy), 64'd1);
      chk("b_row_pre", 64'(b_A_all), 64'(i));
    end
    b_rst_n = 0;
    #1;
    chk("b_rst_busy", 64'(b_init_busy), 64'd0);
    chk("b_rst_CEN", 64'(b_CEN_all), 64'd1);
    chk("b_rst_GWEN", 64'(b_GWEN), 64'hF);
    chk("b_rst_A", 64'(b_A_all), 64'd0);
    chk("b_rst_D", 64'(b_D_all), 64'd0);
    chk("b_rst_ready", 64'(b_req_ready), 64'd0);
    chk("b_rst_done", 64'(b_init_done), 64'd0);
    chk("b_rst_rsp", 64'(b_rsp_valid), 64'd0);
    @(negedge clk);
    b_rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("b_busy", 64'(b_init_busy), 64'd1);
      chk("b_row", 64'(b_A_all), 64'(i));
      chk("b_sweep_CEN", 64'(b_CEN_all), 64'd0);
      chk("b_sweep_GWEN", 64'(b_GWEN), 64'h0);
      chk("b_sweep_D", 64'(b_D_all), 64'hBEEF);
    end
    @(negedge clk);
    chk("b_busy_end", 64'(b_init_busy), 64'd0);
    chk("b_done", 64'(b_init_done), 64'd1);
    // Read every word plus the first out-of-range address
    for (int c = 0; c <= 67; c++) begin
      if (c >= 3) begin
        chk("b_rsp_valid", 64'(b_rsp_valid), 64'd1);
        chk("b_rsp_err", 64'(b_rsp_err), 64'((c - 3) == 64));
        chk("b_rsp_rdata", 64'(b_rsp_rdata), ((c - 3) == 64) ? 64'h0 : 64'hBEEF);
      end
      if (c <= 64) chk("b_ready", 64'(b_req_ready), 64'd1);
      b_req_valid = (c <= 64);
      b_req_we = 0;
      b_req_addr = 16'(c);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
